alu: RTL and testbench

//  Registered 8-bit integer ALU: the scalar compute element of the tiny tensor core.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul.sv | 14 +
 rtl/alu.sv | 55 +++++
 tb/tb_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered 8-bit ALU.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_mul.sv
// Combinational DATA_W x DATA_W multiplier keeping only the low DATA_W bits.
// Kept separate so a pipelined or DSP-based version can replace it later.
module alu_mul #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product
);

  // Same-width context truncates the product to the low DATA_W bits.
  assign product = a * b;

endmodule

// File: rtl/alu.sv
// Registered integer ALU: one opcode applied to two operands, result captured
// on enabled rising edges, cleared asynchronously by an active-low reset.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              enable_in,
  input  logic [2:0]        opcode_in,
  input  logic [DATA_W-1:0] alu_input1,
  input  logic [DATA_W-1:0] alu_input2,
  output logic [DATA_W-1:0] alu_output
);

  alu_op_e           op;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] next_result;

  assign op = alu_op_e'(opcode_in);

  alu_mul #(
    .DATA_W(DATA_W)
  ) u_mul (
    .a      (alu_input1),
    .b      (alu_input2),
    .product(product)
  );

  // Select the combinational result for the current opcode; all eight are defined.
  always_comb begin
    next_result = '0;
    unique case (op)
      ALU_ADD: next_result = alu_input1 + alu_input2;
      ALU_SUB: next_result = alu_input1 - alu_input2;
      ALU_MUL: next_result = product;
      ALU_AND: next_result = alu_input1 & alu_input2;
      ALU_OR:  next_result = alu_input1 | alu_input2;
      ALU_XOR: next_result = alu_input1 ^ alu_input2;
      ALU_SHL: next_result = alu_input1 << alu_input2[2:0];
      ALU_SHR: next_result = alu_input1 >> alu_input2[2:0];
    endcase
  end

  // Result register: reset wins over enable; disabled edges hold the last result.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      alu_output <= '0;
    end else if (enable_in) begin
      alu_output <= next_result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: fixed vector table, hand-written
// reset/enable/latency sequences, and randomized traffic against a reference model.
module tb_alu;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       enable_in;
  logic [2:0] opcode_in;
  logic [7:0] alu_input1;
  logic [7:0] alu_input2;
  logic [7:0] alu_output;

  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clock_in = ~clock_in;

  alu #(
    .DATA_W(8)
  ) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .enable_in (enable_in),
    .opcode_in (opcode_in),
    .alu_input1(alu_input1),
    .alu_input2(alu_input2),
    .alu_output(alu_output)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  // Reference: integer arithmetic reduced modulo 256.
  function automatic logic [7:0] model(input int unsigned op, input int unsigned a,
                                       input int unsigned b);
    int unsigned r;
    int unsigned sh;
    sh = b % 8;
    case (op)
      0: r = (a + b) % 256;
      1: r = (a + 256 - b) % 256;
      2: r = (a * b) % 256;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (a * (2 ** sh)) % 256;
      default: r = a / (2 ** sh);
    endcase
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic en, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    @(negedge clock_in);
    enable_in  = en;
    opcode_in  = op;
    alu_input1 = a;
    alu_input2 = b;
    @(posedge clock_in);
    #1;
  endtask

  vec_t       vecs[10];
  logic [7:0] expected;
  logic       en;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;

  initial begin
    vecs[0] = '{3'd0, 8'd255, 8'd1,   8'd0};
    vecs[1] = '{3'd1, 8'd0,   8'd1,   8'd255};
    vecs[2] = '{3'd2, 8'd15,  8'd17,  8'd255};
    vecs[3] = '{3'd2, 8'd16,  8'd16,  8'd0};
    vecs[4] = '{3'd3, 8'hF0,  8'h3C,  8'h30};
    vecs[5] = '{3'd4, 8'hF0,  8'h3C,  8'hFC};
    vecs[6] = '{3'd5, 8'hF0,  8'h3C,  8'hCC};
    vecs[7] = '{3'd6, 8'h81,  8'd1,   8'h02};
    vecs[8] = '{3'd7, 8'h81,  8'd9,   8'h40};
    vecs[9] = '{3'd1, 8'd200, 8'd56,  8'd144};

    reset_in   = 1'b0;
    enable_in  = 1'b0;
    opcode_in  = 3'd0;
    alu_input1 = 8'd0;
    alu_input2 = 8'd0;
    #1;
    check("reset_init", alu_output, 8'h00);
    @(negedge clock_in);
    reset_in = 1'b1;

    // ADD sweep
    for (int i = 10; i <= 19; i++) begin
      for (int j = 15; j <= 19; j++) begin
        step(1'b1, 3'd0, 8'(i), 8'(j));
        check($sformatf("add_%0d_%0d", i, j), alu_output, 8'(i + j));
      end
    end

    // Fixed vector table: wrap, logic, shift corners
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].op, vecs[k].a, vecs[k].b);
      check($sformatf("vec%0d_op%0d", k, vecs[k].op), alu_output, vecs[k].exp);
    end

    // Async reset while 0x5A is registered and a new result is pending
    step(1'b1, 3'd0, 8'h50, 8'h0A);
    check("pre_reset_5a", alu_output, 8'h5A);
    @(negedge clock_in);
    opcode_in  = 3'd4;
    alu_input1 = 8'h11;
    alu_input2 = 8'h22;
    #2 reset_in = 1'b0;
    #1 check("reset_async", alu_output, 8'h00);
    @(posedge clock_in);
    #1 check("reset_held", alu_output, 8'h00);
    @(negedge clock_in);
    reset_in = 1'b1;
    @(posedge clock_in);
    #1 check("reset_release", alu_output, 8'h33);

    // Enable hold
    step(1'b1, 3'd0, 8'd3, 8'd4);
    check("en_load7", alu_output, 8'd7);
    step(1'b0, 3'd2, 8'd9, 8'd9);
    check("en_hold1", alu_output, 8'd7);
    step(1'b0, 3'd5, 8'hAA, 8'h55);
    check("en_hold2", alu_output, 8'd7);
    step(1'b1, 3'd5, 8'hAA, 8'h55);
    check("en_resume", alu_output, 8'hFF);

    // Latency: inputs changed just after an edge do not show until the next edge
    step(1'b1, 3'd0, 8'd1, 8'd1);
    check("lat_base", alu_output, 8'd2);
    opcode_in  = 3'd1;
    alu_input1 = 8'd50;
    alu_input2 = 8'd8;
    #3 check("lat_no_change", alu_output, 8'd2);
    @(posedge clock_in);
    #1 check("lat_next_edge", alu_output, 8'd42);

    // Randomized traffic against the model
    expected = alu_output;
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (en) expected = model(op, a, b);
      step(en, op, a, b);
      check($sformatf("rand%0d_op%0d", n, op), alu_output, expected);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
